mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_DSTREAK, 4, consecutive data grants allowed while an instruction request waits (range 1..15).
REQ-002 Parameter: TIMEOUT, 63, grant-state cycles without ACCESS before abort (range 1..255).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 iREN  in  1  instruction fetch request; held until iwait low.
REQ-006 iaddr  in  32  fetch address.
REQ-007 iwait  out  1  high while a fetch is pending and not completing.
REQ-008 iload  out  32  fetch data; valid when iREN high and iwait low.
REQ-009 dREN, dWEN  in  1 each  data read/write request; held until dwait low.
REQ-010 daddr, dstore  in  32 each  data address and write data.
REQ-011 dwait  out  1  high while a data access is pending and not completing.
REQ-012 dload  out  32  read data; valid when dREN high and dwait low.
REQ-013 ramREN, ramWEN  out  1 each  RAM read/write strobes.
REQ-014 ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-015 ramload  in  32  RAM read data.
REQ-016 ramstate  in  ramstate_t  FREE, BUSY, ACCESS, ERROR.
REQ-017 err  out  1  sticky error flag; cleared only by RST.

Function
REQ-018 FSM states: IDLE, IGRANT, DGRANT, ABORT.
REQ-019 IDLE: ram strobes low, ramaddr/ramstore 0, iwait=iREN, dwait=(dREN|dWEN).
REQ-020 IDLE -> DGRANT when data request present and (no iREN, or streak < MAX_DSTREAK).
REQ-021 IDLE -> IGRANT when iREN and (no data request, or streak = MAX_DSTREAK).
REQ-022 Streak counter: +1 on each DGRANT entry while iREN high; cleared on IGRANT entry or when iREN low; saturates at MAX_DSTREAK.
REQ-023 IGRANT: ramREN=1, ramaddr=iaddr; iload=ramload combinationally; iwait low only in the cycle ramstate=ACCESS; dwait held high.
REQ-024 DGRANT: ramWEN=dWEN, ramREN=dREN & ~dWEN, ramaddr=daddr, ramstore=dstore; dload=ramload; dwait low only when ramstate=ACCESS; iwait held high.
REQ-025 Grant state -> IDLE the cycle after ACCESS; min transaction latency 2 cycles (IDLE sample + grant/ACCESS).
REQ-026 Requester drops its request in grant state: strobes deassert that cycle, -> IDLE next cycle, no wait pulse.
REQ-027 dREN and dWEN both high: treated as write; err set.
REQ-028 Timeout counter: cleared on grant entry, +1 each grant cycle without ACCESS; reaching TIMEOUT -> ABORT.
REQ-029 ramstate=ERROR in grant state: -> ABORT, err set.
REQ-030 ABORT: one cycle, strobes low, active requester's wait low, its load data 0, err set; then -> IDLE.
REQ-031 Back-to-back requests: IDLE re-arbitrates the cycle after completion; no bubble beyond the single IDLE cycle.

Reset
REQ-032 RST high: state IDLE, streak and timeout counters 0, err 0, all ram outputs 0, iload/dload 0; waits follow IDLE rule.
REQ-033 RST mid-transaction: strobes low the following cycle; the in-flight access is discarded; no ACCESS is reported to the requester.

Structure
REQ-034 arb_state_t enum and ramstate_t in cpu_types_pkg; MAX_DSTREAK and TIMEOUT defaults as package constants.
REQ-035 One sub-module, arb_timeout: loadable saturating counter with clear, enable, and terminal-count output.
REQ-036 Outputs combinational from registered state plus request/ramstate inputs; no combinational path from ramload to any strobe.

Verification
REQ-037 Single fetch: iREN, iaddr=0x40, ACCESS after 2 BUSY -> ramREN=1 with ramaddr=0x40 for 3 cycles; iwait low for one cycle; iload=ramload.
REQ-038 Contention: iREN and dWEN raised together, daddr=0x100 -> DGRANT first with ramWEN=1, then IGRANT.
REQ-039 Starvation: dREN continuous with iREN held, MAX_DSTREAK=4 -> fifth grant is IGRANT.
REQ-040 Timeout: dREN, ramstate stuck BUSY, TIMEOUT=63 -> ABORT after 63 grant cycles; dwait low for one cycle; dload=0; err=1.
REQ-041 Reset mid-write: RST asserted in DGRANT cycle 2 -> ramWEN=0 next cycle; err=0; state IDLE.
REQ-042 Conflict and drop: dREN=dWEN=1 -> write issued, err=1; request dropped in grant -> strobes low that cycle, no dwait pulse.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package cpu_types_pkg;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, ABORT} arb_state_t;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned STREAK_W        = 4;
  localparam int unsigned TMO_W           = 8;
  localparam int unsigned MAX_DSTREAK_DEF = 4;
  localparam int unsigned TIMEOUT_DEF     = 63;

  function automatic logic is_grant(arb_state_t s);
    return (s == IGRANT) || (s == DGRANT);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request ports and RAM-side strobes of the memory arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  logic              err;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arbiter_timeout.sv
// Loadable saturating counter; tc flags that the next enabled count reaches LIMIT.
module arb_timeout #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access with
// anti-starvation streak limit, grant timeout and sticky error flag.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input logic           CLK,
  input logic           RST,
  mem_arbiter_if.master bus
);

  arb_state_t          state;
  arb_state_t          eff_state;
  logic [STREAK_W-1:0] streak;
  logic                err_q;
  logic                abort_dside;

  logic dreq;
  logic acc;
  logic req_live;
  logic pick_d;
  logic pick_i;
  logic tmo_tc;

  assign dreq     = bus.dREN | bus.dWEN;
  assign acc      = (bus.ramstate == ACCESS);
  assign req_live = (state == IGRANT) ? bus.iREN : dreq;
  assign pick_d   = dreq & (~bus.iREN | (streak < STREAK_W'(MAX_DSTREAK)));
  assign pick_i   = bus.iREN & ~pick_d;

  arb_timeout #(.W(TMO_W), .LIMIT(TIMEOUT)) u_tmo (
    .clk      (CLK),
    .rst      (RST),
    .clr      (~is_grant(state)),
    .en       (is_grant(state) & ~acc),
    .load     (1'b0),
    .load_val (TMO_W'(0)),
    .tc       (tmo_tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      streak      <= '0;
      err_q       <= 1'b0;
      abort_dside <= 1'b0;
    end else begin
      if ((state == DGRANT) && bus.dREN && bus.dWEN) begin
        err_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pick_d) begin
            state       <= DGRANT;
            abort_dside <= 1'b1;
          end else if (pick_i) begin
            state       <= IGRANT;
            abort_dside <= 1'b0;
          end
        end
        IGRANT, DGRANT: begin
          if (!req_live || acc) begin
            state <= IDLE;
          end else if ((bus.ramstate == ERROR) || tmo_tc) begin
            state <= ABORT;
            err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Streak only grows while a fetch is actually being held off.
      if (!bus.iREN || ((state == IDLE) && pick_i)) begin
        streak <= '0;
      end else if ((state == IDLE) && pick_d) begin
        streak <= streak + STREAK_W'(1);
      end
    end
  end

  // Reset forces the idle view immediately so nothing in flight is reported.
  assign eff_state = RST ? IDLE : state;

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;
    case (eff_state)
      IGRANT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        bus.iload   = bus.ramload;
        bus.iwait   = bus.iREN & ~acc;
      end
      DGRANT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dload    = bus.ramload;
        bus.dwait    = dreq & ~acc;
      end
      ABORT: begin
        if (abort_dside) bus.dwait = 1'b0;
        else             bus.iwait = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.err = err_q;

endmodule
